// File: rtl/toast_dmem_bridge_if.sv
// Data-memory bus between the core MEM stage and toast_dmem_bridge.
// master = core side, slave = bridge side.
interface toast_dmem_bridge_if;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_wr_data;
  logic        Mem_wr_en;
  logic        Mem_rst;
  logic [31:0] Mem_rd_data;
  logic        Bus_error;

  modport master (
    output Mem_addr, Mem_wr_data, Mem_wr_en, Mem_rst,
    input  Mem_rd_data, Bus_error
  );

  modport slave (
    input  Mem_addr, Mem_wr_data, Mem_wr_en, Mem_rst,
    output Mem_rd_data, Bus_error
  );
endinterface

// File: rtl/toast_dmem_bridge.sv
// Data-memory bridge: word RAM, GPIO, cycle counter and UART TX behind one bus.
// Optional 64-bit cycle counter enabled by defining TOAST_DMEM_CYCLE_CNT_EN.
module toast_dmem_bridge #(
  parameter int unsigned RAM_DEPTH    = 1024,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned GPIO_W       = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  toast_dmem_bridge_if.slave   mem,
  output logic [GPIO_W-1:0]    Gpio_out,
  output logic                 Uart_tx
);

  localparam int unsigned RAM_AW  = $clog2(RAM_DEPTH);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W  = $clog2(CLKS_PER_BIT);

  // Word addresses (byte address >> 2) of the MMIO registers
  localparam logic [29:0] A_GPIO  = 30'h2000_0000;
  localparam logic [29:0] A_CLO   = 30'h2000_0001;
  localparam logic [29:0] A_CHI   = 30'h2000_0002;
  localparam logic [29:0] A_UDATA = 30'h2000_0003;
  localparam logic [29:0] A_USTAT = 30'h2000_0004;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  logic [29:0]       waddr;
  logic              wr_en;
  logic              rd_en;
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_gpio;
  logic              sel_clo;
  logic              sel_udata;
  logic              sel_ustat;
  logic              unused_addr_lsb;

  assign waddr           = mem.Mem_addr[31:2];
  assign wr_en           = mem.Mem_wr_en;
  assign rd_en           = !mem.Mem_wr_en;
  assign ram_hit         = !mem.Mem_addr[31] && (mem.Mem_addr[30:2] < 29'(RAM_DEPTH));
  assign ram_idx         = mem.Mem_addr[RAM_AW+1:2];
  assign sel_gpio        = (waddr == A_GPIO);
  assign sel_clo         = (waddr == A_CLO);
  assign sel_udata       = (waddr == A_UDATA);
  assign sel_ustat       = (waddr == A_USTAT);
  assign unused_addr_lsb = ^mem.Mem_addr[1:0];

  // Word RAM, no reset on contents
  logic [31:0] ram [RAM_DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en && ram_hit) ram[ram_idx] <= mem.Mem_wr_data;
  end

  // Cycle counter and HI shadow
  logic [31:0] cycle_lo_c;
  logic [31:0] cycle_hi_c;
`ifdef TOAST_DMEM_CYCLE_CNT_EN
  logic [63:0] cycle_cnt;
  logic [31:0] cycle_hi_sh;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycle_cnt   <= '0;
      cycle_hi_sh <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (rd_en && sel_clo) cycle_hi_sh <= cycle_cnt[63:32];
    end
  end

  assign cycle_lo_c = cycle_cnt[31:0];
  assign cycle_hi_c = cycle_hi_sh;
`else
  logic unused_sel_clo;
  assign unused_sel_clo = sel_clo;
  assign cycle_lo_c     = '0;
  assign cycle_hi_c     = '0;
`endif

  // TX FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW:0]   wptr;
  logic [FIFO_AW:0]   rptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               overflow;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                      (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign push_req   = wr_en && sel_udata;
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wptr[FIFO_AW-1:0]] <= mem.Mem_wr_data[7:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (FIFO_AW+1)'(1);
      if (pop)  rptr <= rptr + (FIFO_AW+1)'(1);
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      else if (rd_en && sel_ustat)       overflow <= 1'b0;
    end
  end

  // UART transmitter, 8N1 LSB first
  uart_state_e       uart_state;
  uart_state_e       uart_state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_cnt_d;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_d;
  logic [7:0]        shift;
  logic [7:0]        shift_d;
  logic              tx_d;
  logic              bit_done;
  logic              tx_busy;

  assign bit_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx_busy  = (uart_state != UART_IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      uart_state <= UART_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      Uart_tx    <= 1'b1;
    end else begin
      uart_state <= uart_state_d;
      baud_cnt   <= baud_cnt_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      Uart_tx    <= tx_d;
    end
  end

  // Line level is computed from the next state so it changes with the state
  always_comb begin
    uart_state_d = uart_state;
    baud_cnt_d   = baud_cnt;
    bit_idx_d    = bit_idx;
    shift_d      = shift;
    tx_d         = Uart_tx;
    pop          = 1'b0;
    unique case (uart_state)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shift_d      = fifo_mem[rptr[FIFO_AW-1:0]];
          baud_cnt_d   = '0;
          uart_state_d = UART_START;
          tx_d         = 1'b0;
        end
      end
      UART_START: begin
        if (bit_done) begin
          baud_cnt_d   = '0;
          bit_idx_d    = '0;
          uart_state_d = UART_DATA;
          tx_d         = shift[0];
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      UART_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            uart_state_d = UART_STOP;
            tx_d         = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = {1'b0, shift[7:1]};
            tx_d      = shift[1];
          end
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      UART_STOP: begin
        if (bit_done) begin
          baud_cnt_d   = '0;
          uart_state_d = UART_IDLE;
          tx_d         = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      default: uart_state_d = UART_IDLE;
    endcase
  end

  // Read mux and unmapped detect for the address presented this cycle
  logic [31:0] rd_d;
  logic        berr_d;

  always_comb begin
    rd_d   = '0;
    berr_d = 1'b0;
    if (ram_hit) begin
      rd_d = ram[ram_idx];
    end else begin
      case (waddr)
        A_GPIO:  rd_d = 32'(Gpio_out);
        A_CLO:   rd_d = cycle_lo_c;
        A_CHI:   rd_d = cycle_hi_c;
        A_UDATA: rd_d = '0;
        A_USTAT: rd_d = {28'd0, overflow, tx_busy, fifo_empty, fifo_full};
        default: berr_d = 1'b1;
      endcase
    end
  end

  // Registered bus outputs and GPIO
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem.Mem_rd_data <= '0;
      mem.Bus_error   <= 1'b0;
      Gpio_out        <= '0;
    end else begin
      mem.Mem_rd_data <= mem.Mem_rst ? 32'd0 : rd_d;
      mem.Bus_error   <= berr_d;
      if (wr_en && sel_gpio) Gpio_out <= mem.Mem_wr_data[GPIO_W-1:0];
    end
  end

endmodule

// File: tb/tb_toast_dmem_bridge.sv
// Self-checking bench for toast_dmem_bridge: directed vector table, UART
// frame monitor, FIFO overflow sequence and randomized bus traffic vs. a model.
module tb_toast_dmem_bridge;
  localparam int unsigned RAM_DEPTH  = 256;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CPB        = 4;
  localparam int unsigned GPIO_W     = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [GPIO_W-1:0] gpio;
  logic uart_tx;

  toast_dmem_bridge_if bus ();

  toast_dmem_bridge #(
    .RAM_DEPTH   (RAM_DEPTH),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CPB),
    .GPIO_W      (GPIO_W)
  ) dut (
    .Clk     (clk),
    .Reset_n (reset_n),
    .mem     (bus),
    .Gpio_out(gpio),
    .Uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply one bus cycle and return #1 after the capturing edge
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rs);
    bus.Mem_addr    = a;
    bus.Mem_wr_data = d;
    bus.Mem_wr_en   = we;
    bus.Mem_rst     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Software UART receiver: every bit must hold CPB samples, start 0, stop 1
  logic [7:0] rx_q[$];
  logic [9:0] mon_bits;
  bit         mon_ok;
  bit         mon_abort;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && uart_tx === 1'b0) begin
        mon_ok    = 1'b1;
        mon_abort = 1'b0;
        mon_bits  = '0;
        for (int k = 0; k < 10; k++) begin
          for (int s = 0; s < int'(CPB); s++) begin
            if (k != 0 || s != 0) @(negedge clk);
            if (reset_n !== 1'b1) mon_abort = 1'b1;
            if (s == 0) mon_bits[k] = uart_tx;
            else if (uart_tx !== mon_bits[k]) mon_ok = 1'b0;
          end
        end
        if (!mon_abort) begin
          check("uart_frame", {29'd0, mon_ok, mon_bits[9], mon_bits[0]}, 32'h6);
          rx_q.push_back(mon_bits[8:1]);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rst;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_berr;
    logic [7:0]  exp_gpio;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic [31:0] a, input logic [31:0] d, input logic we,
                               input logic rs, input logic chk, input logic [31:0] er,
                               input logic eb, input logic [7:0] eg);
    vec_t v;
    v.addr = a; v.wdata = d; v.we = we; v.rst = rs;
    v.chk_rd = chk; v.exp_rd = er; v.exp_berr = eb; v.exp_gpio = eg;
    vecs.push_back(v);
  endfunction

  // Random-phase reference model
  logic [31:0] ram_m [RAM_DEPTH];
  bit          ram_v [RAM_DEPTH];
  logic [7:0]  gpio_m;
  logic [31:0] unm [5];
  logic [7:0]  fifo_bytes [10];
  logic        cnt_chk;
  logic [31:0] lo1;

  initial begin
`ifdef TOAST_DMEM_CYCLE_CNT_EN
    cnt_chk = 1'b0;
`else
    cnt_chk = 1'b1;
`endif
    reset_n         = 1'b0;
    bus.Mem_addr    = '0;
    bus.Mem_wr_data = '0;
    bus.Mem_wr_en   = 1'b0;
    bus.Mem_rst     = 1'b0;
    #12;
    check("reset_rd_data", bus.Mem_rd_data, 32'h0);
    check("reset_gpio", 32'(gpio), 32'h0);
    check("reset_uart_tx", 32'(uart_tx), 32'h1);
    check("reset_bus_error", 32'(bus.Bus_error), 32'h0);
    #10 reset_n = 1'b1;

    // ---------------- directed vector table ----------------
    addv(32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 0, 32'h0,         0, 8'h00);
    addv(32'h0000_0010, 32'h0,         0, 0, 1, 32'hDEAD_BEEF, 0, 8'h00);
    addv(32'h0000_0014, 32'h1234_5678, 1, 0, 0, 32'h0,         0, 8'h00);
    addv(32'h0000_0014, 32'h0,         0, 1, 1, 32'h0,         0, 8'h00);
    addv(32'h0000_0014, 32'h0,         0, 0, 1, 32'h1234_5678, 0, 8'h00);
    addv(32'h0000_0013, 32'hCAFE_F00D, 1, 0, 1, 32'hDEAD_BEEF, 0, 8'h00);
    addv(32'h0000_0010, 32'h0,         0, 0, 1, 32'hCAFE_F00D, 0, 8'h00);
    addv(32'h8000_0000, 32'h0000_01A5, 1, 0, 1, 32'h0,         0, 8'hA5);
    addv(32'h8000_0002, 32'h0,         0, 0, 1, 32'h0000_00A5, 0, 8'hA5);
    addv(32'h8000_0100, 32'h0,         0, 0, 1, 32'h0,         1, 8'hA5);
    addv(32'h4000_0000, 32'h1111_1111, 1, 0, 1, 32'h0,         1, 8'hA5);
    addv(32'h0000_0010, 32'h0,         0, 0, 1, 32'hCAFE_F00D, 0, 8'hA5);
    addv(32'h0000_03FC, 32'h0BAD_CAFE, 1, 0, 0, 32'h0,         0, 8'hA5);
    addv(32'h0000_03FC, 32'h0,         0, 0, 1, 32'h0BAD_CAFE, 0, 8'hA5);
    addv(32'h0000_0400, 32'h0,         0, 0, 1, 32'h0,         1, 8'hA5);
    addv(32'h8000_000C, 32'h0,         0, 0, 1, 32'h0,         0, 8'hA5);
    addv(32'h8000_0010, 32'h0,         0, 0, 1, 32'h2,         0, 8'hA5);
    addv(32'h8000_0008, 32'hFFFF_FFFF, 1, 0, 1, 32'h0,         0, 8'hA5);
    addv(32'h8000_0010, 32'hFFFF_FFFF, 1, 0, 1, 32'h2,         0, 8'hA5);
    addv(32'h8000_0004, 32'h0,         0, 0, cnt_chk, 32'h0,   0, 8'hA5);
    addv(32'h0000_0018, 32'h0000_0077, 1, 1, 1, 32'h0,         0, 8'hA5);
    addv(32'h0000_0018, 32'h0,         0, 0, 1, 32'h0000_0077, 0, 8'hA5);

    foreach (vecs[i]) begin
      step(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rst);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), bus.Mem_rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_berr", i), 32'(bus.Bus_error), 32'(vecs[i].exp_berr));
      check($sformatf("vec%0d_gpio", i), 32'(gpio), 32'(vecs[i].exp_gpio));
    end

    // ---------------- cycle counter registers ----------------
`ifdef TOAST_DMEM_CYCLE_CNT_EN
    step(32'h8000_0004, 32'h0, 1'b0, 1'b0);
    lo1 = bus.Mem_rd_data;
    step(32'h8000_0004, 32'h0, 1'b0, 1'b0);
    check("cycle_lo_increments", bus.Mem_rd_data - lo1, 32'h1);
    step(32'h8000_0008, 32'h0, 1'b0, 1'b0);
    check("cycle_hi_shadow", bus.Mem_rd_data, 32'h0);
    check("cycle_hi_berr", 32'(bus.Bus_error), 32'h0);
`else
    step(32'h8000_0004, 32'h0, 1'b0, 1'b0);
    check("cycle_lo_zero", bus.Mem_rd_data, 32'h0);
    check("cycle_lo_berr", 32'(bus.Bus_error), 32'h0);
    step(32'h8000_0008, 32'h0, 1'b0, 1'b0);
    check("cycle_hi_zero", bus.Mem_rd_data, 32'h0);
    check("cycle_hi_berr", 32'(bus.Bus_error), 32'h0);
`endif

    // ---------------- single UART byte ----------------
    rx_q.delete();
    step(32'h8000_000C, 32'h0000_AB55, 1'b1, 1'b0);
    check("uart_idle_at_push", 32'(uart_tx), 32'h1);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    check("uart_start_next", 32'(uart_tx), 32'h0);
    idle(18);
    step(32'h8000_0010, 32'h0, 1'b0, 1'b0);
    check("status_busy_mid", bus.Mem_rd_data & 32'h4, 32'h4);
    idle(30);
    step(32'h8000_0010, 32'h0, 1'b0, 1'b0);
    check("status_after_frame", bus.Mem_rd_data, 32'h2);
    check("uart_one_byte", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) check("uart_byte", 32'(rx_q[0]), 32'h55);

    // ---------------- FIFO fill and overflow ----------------
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      fifo_bytes[i] = 8'($urandom());
      step(32'h8000_000C, {24'h0, fifo_bytes[i]}, 1'b1, 1'b0);
    end
    step(32'h8000_0010, 32'h0, 1'b0, 1'b0);
    check("status_full_ovf", bus.Mem_rd_data, 32'hD);
    step(32'h8000_0010, 32'h0, 1'b0, 1'b0);
    check("status_ovf_cleared", bus.Mem_rd_data, 32'h5);
    idle(9 * (10 * CPB + 1) + 20);
    check("uart_nine_bytes", 32'(rx_q.size()), 32'h9);
    for (int i = 0; i < 9; i++)
      if (i < rx_q.size()) check($sformatf("uart_fifo_byte%0d", i), 32'(rx_q[i]), 32'(fifo_bytes[i]));
    step(32'h8000_0010, 32'h0, 1'b0, 1'b0);
    check("status_drained", bus.Mem_rd_data, 32'h2);

    // ---------------- randomized traffic vs. model ----------------
    unm[0] = 32'h8000_0014; unm[1] = 32'h8000_0100; unm[2] = 32'h4000_0000;
    unm[3] = 32'h0000_0400; unm[4] = 32'hFFFF_FFFC;
    gpio_m = 8'hA5;
    foreach (ram_v[i]) ram_v[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      int unsigned idx;
      logic [31:0] a;
      logic [31:0] d;
      logic we;
      logic rs;
      logic chk;
      logic [31:0] er;
      logic eb;
      op  = $urandom_range(0, 5);
      we  = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 7) == 0);
      d   = $urandom();
      chk = 1'b1;
      er  = 32'h0;
      eb  = 1'b0;
      idx = 0;
      case (op)
        0, 1: begin
          idx = ($urandom_range(0, 4) == 0) ? RAM_DEPTH - 1 : $urandom_range(0, 15);
          a   = 32'(idx * 4) | 32'($urandom_range(0, 3));
          chk = ram_v[idx];
          er  = ram_m[idx];
        end
        2: begin a = 32'h8000_0000; er = {24'h0, gpio_m}; end
        3: begin a = unm[$urandom_range(0, 4)]; eb = 1'b1; end
        4: begin a = 32'h8000_0010; er = 32'h2; end
        default: begin
          a   = ($urandom_range(0, 1) == 0) ? 32'h8000_0004 : 32'h8000_0008;
          chk = cnt_chk;
        end
      endcase
      if (rs) begin chk = 1'b1; er = 32'h0; end
      step(a, d, we, rs);
      if (we && op <= 1) begin ram_m[idx] = d; ram_v[idx] = 1'b1; end
      if (we && op == 2) gpio_m = d[7:0];
      if (chk) check($sformatf("rand%0d_rd", n), bus.Mem_rd_data, er);
      check($sformatf("rand%0d_berr", n), 32'(bus.Bus_error), 32'(eb));
      check($sformatf("rand%0d_gpio", n), 32'(gpio), 32'(gpio_m));
    end

    // ---------------- reset in the middle of a frame ----------------
    rx_q.delete();
    for (int i = 0; i < 3; i++) step(32'h8000_000C, 32'(8'hC0 + i), 1'b1, 1'b0);
    idle(10);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_uart_tx", 32'(uart_tx), 32'h1);
    check("mid_reset_gpio", 32'(gpio), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(200);
    check("mid_reset_no_frames", 32'(rx_q.size()), 32'h0);
    step(32'h8000_0010, 32'h0, 1'b0, 1'b0);
    check("mid_reset_fifo_empty", bus.Mem_rd_data, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
